dmem_loader: RTL and testbench
==============================

# dmem_loader

Hardware data-memory loader for the LEGv8 single-cycle and pipeline tops. Receives a little-endian byte stream, packs it into 64-bit words, and writes them into data memory from a start index. The CPU is held in reset until the load finishes, which replaces the file-based data memory initialisation path with a synthesizable one. It is the writing counterpart of the bench's post-run data-memory dump.

## Interface
Parameters:
- WORD, 64, data word width in bits; must be a multiple of 8.
- SIZE, 1024, data memory depth in words.
- BASE_IDX, 0, first word index written.
- ADDR_W, $clog2(SIZE), word-index width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle load request; sampled only in IDLE.
- num_words  in  ADDR_W+1  number of words to load; sampled with start.
- in_valid  in  1  byte stream valid.
- in_data  in  8  byte, least significant byte of each word first.
- in_ready  out  1  byte stream ready.
- mem_we  out  1  data memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word index being written.
- mem_wdata  out  WORD  packed word.
- cpu_rst_n  out  1  CPU reset, active-low; low from rst_n until load completes.
- busy  out  1  high in RECV or WRITE.
- done  out  1  one-cycle pulse when the load completes.
- err  out  1  sticky; set on a rejected start; cleared by the next accepted start.

## Operation
- FSM states: IDLE, RECV, WRITE, RELEASE.
- IDLE:
  - start=1 with BASE_IDX+num_words > SIZE: reject, err<=1, stay in IDLE.
  - start=1 with num_words==0: go to RELEASE.
  - start=1 otherwise: latch the count, word index <= BASE_IDX, byte counter <= 0, err<=0, go to RECV.
- RECV:
  - in_ready=1.
  - Each in_valid&in_ready places in_data into byte lane byte_cnt of the shift/assembly register.
  - Accepting byte WORD/8-1 moves to WRITE.
- WRITE:
  - mem_we=1 for exactly one cycle with mem_addr = current index and mem_wdata = assembled word.
  - Then the index increments and the remaining count decrements.
  - If the remaining count reaches 0, go to RELEASE; else go to RECV.
- RELEASE: cpu_rst_n<=1, done=1 for one cycle, then IDLE.
- cpu_rst_n stays 1 after the first completion; a later start drives it 0 again for the whole reload.
- start while busy is ignored; err is not set.
- Byte count wraps modulo WORD/8. The index never exceeds SIZE-1 because of the start check.

## Timing
- Reset values:
  - State IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rst_n=0, busy=0, done=0, err=0.
- start in cycle t: RECV and in_ready=1 in cycle t+1.
- The 8th byte accepted in cycle t gives mem_we=1 in cycle t+1; in_ready=0 during WRITE.
- Minimum 9 cycles per word: 8 bytes plus 1 write.
- Last WRITE in cycle t: done=1 and cpu_rst_n=1 in cycle t+1.
- num_words==0: done is in cycle t+1 after start.
- in_valid held low stalls RECV indefinitely with no timeout; partial bytes are retained.
- rst_n asserted mid-load: immediate return to reset values and the partial word is discarded. Already-written words are not undone.
- All outputs are registered; no combinational path from input to output.

## Structure
- A shared package holds the WORD/INST_SIZE constants (from the common header) and the state enum loader_state_t.
- The natural sub-module is byte_packer: byte-lane assembly plus byte counter, with a word_valid pulse.
- FSM, index counter and cpu_rst_n control live in the top.

## Test plan
- Reset, then start with num_words=1 and bytes 0x08..0x01 → one mem_we with mem_addr=0 and mem_wdata=0x0102030405060708, done one cycle later, cpu_rst_n 0→1.
- BASE_IDX=3, num_words=100, random words with random in_valid gaps → exactly 100 writes at indices 3..102; the data equals a reference model; err=0.
- num_words=0 → done at start+1, no mem_we, cpu_rst_n=1.
- SIZE=1024, BASE_IDX=3, num_words=1022 → err=1, no state change, in_ready=0. A subsequent valid start clears err.
- rst_n pulsed low after 3 bytes of word 2 → all outputs at reset values. A new load of 1 word writes index BASE_IDX with only the new bytes.
- start asserted during RECV → ignored; the word count and addresses of the ongoing load are unchanged.

Source files
------------

// File: rtl/dmem_loader_pkg.sv
// Shared constants and the loader state encoding for the data-memory loader.
package dmem_loader_pkg;

    localparam int WORD_W    = 64;
    localparam int INST_SIZE = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RELEASE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/dmem_loader_byte_packer.sv
// Assembles a little-endian byte stream into WORD-bit words; word_valid marks
// the cycle in which the last byte of a word is taken.
module dmem_loader_byte_packer #(
    parameter int WORD = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            take,
    input  logic [7:0]      byte_in,
    output logic [WORD-1:0] word,
    output logic            word_valid
);

    localparam int BPW   = WORD / 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [WORD-1:0]  word_q;
    logic             last_lane;

    assign last_lane  = (cnt_q == CNT_W'(BPW - 1));
    assign word_valid = take && last_lane;
    assign word       = word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (take) begin
            word_q[{cnt_q, 3'b000} +: 8] <= byte_in;
            cnt_q <= last_lane ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_loader.sv
// Loads a byte stream into data memory as packed words starting at BASE_IDX,
// holding the CPU in reset until the load completes.
//
// state      | meaning
// IDLE       | waiting for start; range-checks the request
// RECV       | accepting bytes of the current word
// WRITE      | one-cycle memory write of the assembled word
// RELEASE    | releases CPU reset and pulses done
module dmem_loader
    import dmem_loader_pkg::*;
#(
    parameter int WORD     = 64,
    parameter int SIZE     = 1024,
    parameter int BASE_IDX = 0,
    parameter int ADDR_W   = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD-1:0]   mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    loader_state_t     state_q, state_d;
    logic [ADDR_W:0]   rem_q;
    logic [ADDR_W-1:0] idx_q;
    logic              in_ready_q, mem_we_q, cpu_rst_q, busy_q, done_q, err_q;
    logic              req, too_big, accept, take, word_valid;

    assign req     = (state_q == ST_IDLE) && start;
    assign too_big = (32'(BASE_IDX) + 32'(num_words)) > 32'(SIZE);
    assign accept  = req && !too_big;
    assign take    = in_valid && in_ready_q;

    dmem_loader_byte_packer #(.WORD(WORD)) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept),
        .take      (take),
        .byte_in   (in_data),
        .word      (mem_wdata),
        .word_valid(word_valid)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = (num_words == '0) ? ST_RELEASE : ST_RECV;
            end
            ST_RECV: begin
                if (word_valid) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = (rem_q == (ADDR_W+1)'(1)) ? ST_RELEASE : ST_RECV;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cpu_rst_q  <= 1'b0;
            err_q      <= 1'b0;
            rem_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == ST_RECV);
            mem_we_q   <= (state_d == ST_WRITE);
            busy_q     <= (state_d == ST_RECV) || (state_d == ST_WRITE);
            done_q     <= (state_d == ST_RELEASE);
            if (state_d == ST_RELEASE) begin
                cpu_rst_q <= 1'b1;
            end else if (accept) begin
                cpu_rst_q <= 1'b0;
            end
            if (req) begin
                err_q <= too_big;
            end
            if (accept) begin
                rem_q <= num_words;
                idx_q <= ADDR_W'(BASE_IDX);
            end else if (state_q == ST_WRITE) begin
                rem_q <= rem_q - (ADDR_W+1)'(1);
                idx_q <= idx_q + ADDR_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = idx_q;
    assign cpu_rst_n = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dmem_loader.sv
// Self-checking bench for dmem_loader: table of start requests, randomized
// loads against a write-list reference model, and reset/start-while-busy cases.
module tb_dmem_loader;

    localparam int SIZE = 1024;
    localparam int BASE = 3;
    localparam int AW   = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   num_words = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready, mem_we, cpu_rst_n, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;

    dmem_loader #(.WORD(64), .SIZE(SIZE), .BASE_IDX(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } wr_t;
    wr_t got_q[$];
    wr_t exp_q[$];

    always @(negedge clk) begin
        if (rst_n && mem_we) got_q.push_back('{mem_addr, mem_wdata});
    end

    typedef struct {
        int nw;
        bit exp_err;
        bit exp_busy;
        bit exp_done;
        bit exp_cpu;
        int gap;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic do_start(input int nw);
        @(negedge clk);
        start = 1'b1;
        num_words = (AW+1)'(nw);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_bytes(input logic [63:0] w, input int first, input int n, input int gap);
        int k = first;
        int budget = 0;
        while (k < n) begin
            @(negedge clk);
            if (in_ready && ($urandom_range(99) >= gap)) begin
                in_valid = 1'b1;
                in_data  = w[8*k +: 8];
                k++;
            end else begin
                in_valid = 1'b0;
            end
            budget++;
            if (budget > 2000) begin
                n_cmp++;
                n_err++;
                $display("FAIL byte_timeout: actual=%0d bytes required=%0d", k, n);
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic send_word(input logic [63:0] w, input int first, input int gap);
        send_bytes(w, first, 8, gap);
        @(negedge clk);
        in_valid = 1'b0;
        chk("write_strobe", mem_we, 1'b1);
        chk("in_ready_in_write", in_ready, 1'b0);
    endtask

    task automatic finish_load();
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
        chk("cpu_released", cpu_rst_n, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
    endtask

    task automatic check_writes();
        int n;
        chk("write_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("write_addr[%0d]", i), got_q[i].addr, exp_q[i].addr);
            chk($sformatf("write_data[%0d]", i), got_q[i].data, exp_q[i].data);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic load_body(input int nw, input int gap, input bit fixed);
        logic [63:0] w;
        for (int i = 0; i < nw; i++) begin
            w = fixed ? 64'h0102_0304_0506_0708 : {$urandom, $urandom};
            exp_q.push_back('{AW'(BASE + i), w});
            send_word(w, 0, gap);
        end
        finish_load();
        check_writes();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_mem_we"}, mem_we, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, '0);
        chk({tag, "_mem_wdata"}, mem_wdata, '0);
        chk({tag, "_cpu_rst_n"}, cpu_rst_n, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [63:0] wa, wb;

        vecs = '{
            '{1022, 1'b1, 1'b0, 1'b0, 1'b1, 0},
            '{2047, 1'b1, 1'b0, 1'b0, 1'b1, 0},
            '{2,    1'b0, 1'b1, 1'b0, 1'b0, 20},
            '{0,    1'b0, 1'b0, 1'b1, 1'b1, 0},
            '{1023, 1'b1, 1'b0, 1'b0, 1'b1, 0},
            '{1,    1'b0, 1'b1, 1'b0, 1'b0, 50},
            '{1021, 1'b0, 1'b1, 1'b0, 1'b0, 0}
        };

        // Reset state
        @(negedge clk);
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single fixed word, bytes 0x08..0x01
        got_q.delete();
        exp_q.delete();
        do_start(1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_in_ready", in_ready, 1'b1);
        chk("t1_cpu_held", cpu_rst_n, 1'b0);
        load_body(1, 0, 1'b1);

        // Table of start requests
        foreach (vecs[v]) begin
            got_q.delete();
            exp_q.delete();
            do_start(vecs[v].nw);
            chk($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
            chk($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
            chk($sformatf("vec%0d_in_ready", v), in_ready, vecs[v].exp_busy);
            chk($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
            chk($sformatf("vec%0d_cpu", v), cpu_rst_n, vecs[v].exp_cpu);
            if (vecs[v].exp_busy) begin
                load_body(vecs[v].nw, vecs[v].gap, 1'b0);
            end else begin
                @(negedge clk);
                chk($sformatf("vec%0d_done_after", v), done, 1'b0);
                chk($sformatf("vec%0d_idle_busy", v), busy, 1'b0);
                check_writes();
            end
        end

        // 100 random words with random stream gaps
        got_q.delete();
        exp_q.delete();
        do_start(100);
        chk("rand_busy", busy, 1'b1);
        load_body(100, $urandom_range(60, 10), 1'b0);
        chk("rand_err", err, 1'b0);

        // Reset in the middle of word 2
        got_q.delete();
        exp_q.delete();
        do_start(3);
        wa = {$urandom, $urandom};
        wb = {$urandom, $urandom};
        exp_q.push_back('{AW'(BASE), wa});
        send_word(wa, 0, 30);
        send_bytes(wb, 0, 3, 30);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        check_writes();
        @(negedge clk);
        rst_n = 1'b1;
        do_start(1);
        chk("after_reset_busy", busy, 1'b1);
        load_body(1, 30, 1'b0);

        // Start pulsed during RECV is ignored
        got_q.delete();
        exp_q.delete();
        do_start(3);
        wa = {$urandom, $urandom};
        exp_q.push_back('{AW'(BASE), wa});
        send_bytes(wa, 0, 4, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        start     = 1'b1;
        num_words = (AW+1)'(1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_err", err, 1'b0);
        chk("busy_start_busy", busy, 1'b1);
        chk("busy_start_ready", in_ready, 1'b1);
        send_word(wa, 4, 0);
        for (int i = 1; i < 3; i++) begin
            wb = {$urandom, $urandom};
            exp_q.push_back('{AW'(BASE + i), wb});
            send_word(wb, 0, 25);
        end
        finish_load();
        check_writes();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
